// File: rtl/fir_pkg.sv
// Shared constants, state encoding and lane packing helper for the FIR sample buffer.
package fir_pkg;

   localparam int unsigned DW         = 18;
   localparam int unsigned AW         = 12;
   localparam int unsigned LANES      = 4;
   localparam int unsigned HIST_DEPTH = LANES << AW;
   localparam int unsigned LW         = $clog2(LANES);
   localparam int unsigned IW         = $clog2(HIST_DEPTH);
   localparam int unsigned WORD_W     = LANES * DW;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_START,
      ST_BUSY
   } state_e;

   // Lane 0 (newest) occupies the most significant slice of the read word.
   function automatic int unsigned lane_lsb(input int unsigned lane);
      return (LANES - 1 - lane) * DW;
   endfunction

endpackage

// File: rtl/fir_sample_bank.sv
// One history bank: simple dual-port synchronous RAM, read-first, registered read.
module fir_sample_bank
   import fir_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_sample_buffer.sv
// Circular 16384-sample history feeding the 4-lane FIR MAC: write FSM, pointer,
// per-bank read address generation and output lane mux.
module fir_sample_buffer
   import fir_pkg::*;
#(
   parameter bit CLR_EN = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DW-1:0]     in_sample,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AW-1:0]     addr_data,
   output logic [WORD_W-1:0] datain,
   output logic              datain_ready,
   input  logic              dataout_ready,
   output logic              busy
);

   state_e          state_q, state_d;
   logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [IW-1:0]   wp_q, wp_d;
   logic [IW-1:0]   n_q, n_d;
   logic            in_ready_q, in_ready_d;
   logic            busy_q, busy_d;
   logic            dr_q, dr_d;
   logic [LW-1:0]   sel_q [LANES];
   logic [LW-1:0]   sel_d [LANES];
   logic            accept;

   logic            bank_we    [LANES];
   logic [AW-1:0]   bank_waddr;
   logic [DW-1:0]   bank_wdata;
   logic [AW-1:0]   bank_raddr [LANES];
   logic [DW-1:0]   bank_rdata [LANES];

   assign accept = (state_q == ST_IDLE) && in_ready_q && in_valid;

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      wp_d       = wp_q;
      n_d        = n_q;
      in_ready_d = in_ready_q;
      busy_d     = busy_q;
      dr_d       = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d    = ST_IDLE;
               in_ready_d = 1'b1;
            end
         end
         ST_IDLE: begin
            in_ready_d = 1'b1;
            if (accept) begin
               wp_d       = wp_q + 1'b1;
               n_d        = wp_q;
               in_ready_d = 1'b0;
               dr_d       = 1'b1;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            busy_d  = 1'b1;
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (dataout_ready) begin
               busy_d     = 1'b0;
               in_ready_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      bank_waddr = wp_q[IW-1:LW];
      bank_wdata = in_sample;
      for (int unsigned b = 0; b < LANES; b++) begin
         bank_we[b] = accept && (wp_q[LW-1:0] == LW'(b));
      end
      if (state_q == ST_CLEAR) begin
         bank_waddr = clr_cnt_q;
         bank_wdata = '0;
         for (int unsigned b = 0; b < LANES; b++) begin
            bank_we[b] = 1'b1;
         end
      end
   end

   // Bank b holds lane (n - b) mod 4; its word is the upper bits of (n - lane) minus k.
   always_comb begin
      for (int unsigned b = 0; b < LANES; b++) begin
         logic [LW-1:0] lane;
         logic [IW-1:0] base;
         lane          = n_q[LW-1:0] - LW'(b);
         base          = n_q - IW'(lane);
         bank_raddr[b] = base[IW-1:LW] - addr_data;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         sel_d[i] = n_q[LW-1:0] - LW'(i);
      end
   end

   always_comb begin
      datain = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         datain[lane_lsb(i) +: DW] = bank_rdata[sel_q[i]];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         if (CLR_EN) begin
            state_q <= ST_CLEAR;
         end else begin
            state_q <= ST_IDLE;
         end
         clr_cnt_q  <= '0;
         wp_q       <= '0;
         n_q        <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         dr_q       <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) begin
            sel_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         wp_q       <= wp_d;
         n_q        <= n_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         dr_q       <= dr_d;
         for (int unsigned i = 0; i < LANES; i++) begin
            sel_q[i] <= sel_d[i];
         end
      end
   end

   for (genvar b = 0; b < LANES; b++) begin : g_bank
      fir_sample_bank u_bank (
         .clock   (clock),
         .reset   (reset),
         .we_i    (bank_we[b]),
         .waddr_i (bank_waddr),
         .wdata_i (bank_wdata),
         .raddr_i (bank_raddr[b]),
         .rdata_o (bank_rdata[b])
      );
   end

   assign in_ready     = in_ready_q;
   assign busy         = busy_q;
   assign datain_ready = dr_q;

endmodule

// File: tb/tb_fir_sample_buffer.sv
// Directed bench for fir_sample_buffer: clear, handshake, backpressure, wrap, raw bits, reset.
module tb_fir_sample_buffer;

   logic        clock;
   logic        reset;
   logic [17:0] in_sample;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] addr_data;
   logic [71:0] datain;
   logic        datain_ready;
   logic        dataout_ready;
   logic        busy;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   fir_sample_buffer #(.CLR_EN(1'b1)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_sample     (in_sample),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .addr_data     (addr_data),
      .datain        (datain),
      .datain_ready  (datain_ready),
      .dataout_ready (dataout_ready),
      .busy          (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] pack(input logic [17:0] l0, input logic [17:0] l1,
                                        input logic [17:0] l2, input logic [17:0] l3);
      return {l0, l1, l2, l3};
   endfunction

   task automatic do_reset();
      reset         = 1'b1;
      in_valid      = 1'b0;
      dataout_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Called on cycle 1 after reset; in_ready must stay low through cycle 4096.
   task automatic wait_clear();
      int unsigned rdy_seen = 0;
      int unsigned dr_seen  = 0;
      for (int unsigned c = 1; c < 4096; c++) begin
         tick();
         if (in_ready)     rdy_seen++;
         if (datain_ready) dr_seen++;
      end
      check("clear_in_ready_low", 72'(rdy_seen), 72'd0);
      check("clear_no_dr", 72'(dr_seen), 72'd0);
      tick();
      check("clear_in_ready_rise", 72'(in_ready), 72'd1);
   endtask

   task automatic accept_and_release(input int unsigned gap);
      int unsigned w = 0;
      while (!in_ready && w < 8) begin
         tick();
         w++;
      end
      check("in_ready_wait", 72'(in_ready), 72'd1);
      tick();
      check("dr_pulse", 72'({datain_ready, in_ready}), 72'b10);
      in_valid = 1'b0;
      tick();
      check("dr_width_busy", 72'({datain_ready, busy}), 72'b01);
      for (int unsigned g = 1; g < gap; g++) tick();
      dataout_ready = 1'b1;
      tick();
      dataout_ready = 1'b0;
   endtask

   task automatic push(input logic [17:0] v, input int unsigned gap);
      in_sample = v;
      in_valid  = 1'b1;
      accept_and_release(gap);
   endtask

   task automatic rd(input logic [11:0] k, input logic [71:0] exp, input string tag);
      addr_data = k;
      tick();
      check(tag, datain, exp);
   endtask

   initial begin
      int unsigned cnt;
      reset         = 1'b1;
      in_sample     = '0;
      in_valid      = 1'b0;
      addr_data     = '0;
      dataout_ready = 1'b0;
      tick();

      // Reset values and clear sweep, with a zero sample waiting through CLEAR.
      do_reset();
      check("rst_in_ready", 72'(in_ready), 72'd0);
      check("rst_dr", 72'(datain_ready), 72'd0);
      check("rst_busy", 72'(busy), 72'd0);
      check("rst_datain", datain, 72'd0);
      in_sample = 18'd0;
      in_valid  = 1'b1;
      wait_clear();
      accept_and_release(1);
      for (int unsigned k = 0; k < 4096; k++) rd(12'(k), 72'd0, "clear_read");

      // Basic: index 0 already holds 0, samples 1..5 go to indices 1..5.
      for (int unsigned s = 1; s <= 5; s++) push(18'(s), 3);
      rd(12'd0, pack(18'd5, 18'd4, 18'd3, 18'd2), "basic_addr0");
      rd(12'd1, pack(18'd1, 18'd0, 18'd0, 18'd0), "basic_addr1");

      // Backpressure: sample 7 held valid through BUSY.
      in_sample = 18'd7;
      in_valid  = 1'b1;
      tick();
      check("bp_accept", 72'(datain_ready), 72'd1);
      tick();
      check("bp_busy", 72'(busy), 72'd1);
      cnt = 0;
      for (int unsigned c = 0; c < 20; c++) begin
         tick();
         if (datain_ready || in_ready) cnt++;
      end
      check("bp_hold", 72'(cnt), 72'd0);
      dataout_ready = 1'b1;
      tick();
      dataout_ready = 1'b0;
      check("bp_release", 72'({in_ready, datain_ready, busy}), 72'b100);
      tick();
      check("bp_reaccept", 72'({datain_ready, in_ready}), 72'b10);
      in_valid = 1'b0;
      tick();
      check("bp_single", 72'(datain_ready), 72'd0);
      dataout_ready = 1'b1;
      tick();
      dataout_ready = 1'b0;
      rd(12'd0, pack(18'd7, 18'd7, 18'd5, 18'd4), "bp_addr0");

      // Wrap: 16390 samples from a fresh history.
      do_reset();
      wait_clear();
      for (int unsigned i = 0; i < 16390; i++) push(18'(i), 1);
      rd(12'd0, pack(18'd16389, 18'd16388, 18'd16387, 18'd16386), "wrap_addr0");
      rd(12'd4095, pack(18'd9, 18'd8, 18'd7, 18'd6), "wrap_addr4095");
      rd(12'd4094, pack(18'd13, 18'd12, 18'd11, 18'd10), "wrap_addr4094");

      // Raw bit patterns with the sign bit set.
      push(18'h20000, 1);
      push(18'h3FFFF, 1);
      rd(12'd0, pack(18'h3FFFF, 18'h20000, 18'd16389, 18'd16388), "sign_addr0");

      // Reset while BUSY.
      in_sample = 18'h01234;
      in_valid  = 1'b1;
      tick();
      check("mid_accept", 72'(datain_ready), 72'd1);
      in_valid = 1'b0;
      tick();
      check("mid_busy", 72'(busy), 72'd1);
      do_reset();
      check("mid_rst_flags", 72'({in_ready, datain_ready, busy}), 72'd0);
      check("mid_rst_datain", datain, 72'd0);
      wait_clear();
      rd(12'd0, 72'd0, "mid_addr0");
      rd(12'd1, 72'd0, "mid_addr1");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
